// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared datapath widths and MEM/WB control bundle for the five-stage core
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // MEM/WB control bits carried from ID/EX through EX/MEM
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
  } memwb_ctrl_t;

  // A bubble carries no side effects: no register write, no memory access
  localparam memwb_ctrl_t CTRL_BUBBLE = '0;

  // Writes to x0 are architecturally discarded, so never store them as writes
  function automatic memwb_ctrl_t suppress_x0(input memwb_ctrl_t ctrl, input logic rd_is_zero);
    memwb_ctrl_t res;
    res = ctrl;
    if (rd_is_zero) begin
      res.reg_write = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - free-running 32-bit count of data cache stall cycles
module stall_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic [31:0] count_o
);

  // Count every stalled cycle; natural wrap from all-ones back to zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= 32'd0;
    end else if (en_i) begin
      count_o <= count_o + 32'd1;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall hold, deferred flush and forwarding taps; optional stall counter under EX_MEM_STALL_CNT_EN
module ex_mem_reg #(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int RA_W = cpu_pkg::RA_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            Valid_i,
  input  logic [XLEN-1:0] ALUResult_i,
  input  logic [XLEN-1:0] MemData_i,
  input  logic [RA_W-1:0] RdAddr_i,
  input  logic            RegWrite_i,
  input  logic            MemtoReg_i,
  input  logic            MemRead_i,
  input  logic            MemWrite_i,
  input  logic            Stall_i,
  input  logic            Flush_i,
  output logic            Valid_o,
  output logic [XLEN-1:0] ALUResult_o,
  output logic [XLEN-1:0] MemData_o,
  output logic [RA_W-1:0] RdAddr_o,
  output logic            RegWrite_o,
  output logic            MemtoReg_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            MemReq_o,
`ifdef EX_MEM_STALL_CNT_EN
  output logic            FwdEn_o,
  output logic [31:0]     StallCnt_o
`else
  output logic            FwdEn_o
`endif
);

  import cpu_pkg::*;

  logic            valid_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] mem_data_q;
  logic [RA_W-1:0] rd_q;
  memwb_ctrl_t     ctrl_q;
  memwb_ctrl_t     ctrl_in;
  memwb_ctrl_t     ctrl_live;
  logic            flush_pending_q;

  assign ctrl_in = suppress_x0('{reg_write:  RegWrite_i,
                                 mem_to_reg: MemtoReg_i,
                                 mem_read:   MemRead_i,
                                 mem_write:  MemWrite_i},
                               (RdAddr_i == '0));

  // Reset, then stall hold (remembering any flush), then bubble on flush, else capture EX
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q         <= 1'b0;
      alu_q           <= '0;
      mem_data_q      <= '0;
      rd_q            <= '0;
      ctrl_q          <= CTRL_BUBBLE;
      flush_pending_q <= 1'b0;
    end else if (Stall_i) begin
      if (Flush_i) begin
        flush_pending_q <= 1'b1;
      end
    end else if (Flush_i || flush_pending_q) begin
      valid_q         <= 1'b0;
      ctrl_q          <= CTRL_BUBBLE;
      flush_pending_q <= 1'b0;
    end else begin
      valid_q    <= Valid_i;
      alu_q      <= ALUResult_i;
      mem_data_q <= MemData_i;
      rd_q       <= RdAddr_i;
      ctrl_q     <= ctrl_in;
    end
  end

  // An invalid entry must never request memory or write a register
  assign ctrl_live   = valid_q ? ctrl_q : CTRL_BUBBLE;

  assign Valid_o     = valid_q;
  assign ALUResult_o = alu_q;
  assign MemData_o   = mem_data_q;
  assign RdAddr_o    = rd_q;
  assign RegWrite_o  = ctrl_live.reg_write;
  assign MemtoReg_o  = ctrl_live.mem_to_reg;
  assign MemRead_o   = ctrl_live.mem_read;
  assign MemWrite_o  = ctrl_live.mem_write;

  // Both taps depend only on registered state, so a stall keeps them stable
  assign MemReq_o    = ctrl_live.mem_read | ctrl_live.mem_write;
  assign FwdEn_o     = ctrl_live.reg_write & ~ctrl_live.mem_to_reg;

`ifdef EX_MEM_STALL_CNT_EN
  stall_counter u_stall_counter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (Stall_i),
    .count_o (StallCnt_o)
  );
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg: vector table, corner sequences, random vs reference model
module tb_ex_mem_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i, rw_i, m2r_i, mr_i, mw_i, st_i, fl_i;
  logic [31:0] alu_i, md_i;
  logic [4:0]  rd_i;
  logic        v_o, rw_o, m2r_o, mr_o, mw_o, req_o, fwd_o;
  logic [31:0] alu_o, md_o;
  logic [4:0]  rd_o;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] cnt_o;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ex_mem_reg dut (
    .clk_i(clk), .rst_i(rst), .Valid_i(v_i), .ALUResult_i(alu_i), .MemData_i(md_i),
    .RdAddr_i(rd_i), .RegWrite_i(rw_i), .MemtoReg_i(m2r_i), .MemRead_i(mr_i),
    .MemWrite_i(mw_i), .Stall_i(st_i), .Flush_i(fl_i), .Valid_o(v_o),
    .ALUResult_o(alu_o), .MemData_o(md_o), .RdAddr_o(rd_o), .RegWrite_o(rw_o),
    .MemtoReg_o(m2r_o), .MemRead_o(mr_o), .MemWrite_o(mw_o), .MemReq_o(req_o),
`ifdef EX_MEM_STALL_CNT_EN
    .FwdEn_o(fwd_o), .StallCnt_o(cnt_o)
`else
    .FwdEn_o(fwd_o)
`endif
  );

  // reference model: architectural contents of the stage
  logic        m_valid, m_rw, m_m2r, m_mr, m_mw, m_fp;
  logic [31:0] m_alu, m_md, m_cnt;
  logic [4:0]  m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic model_edge();
    if (rst) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_mr = 0; m_mw = 0; m_fp = 0;
      m_alu = 0; m_md = 0; m_rd = 0; m_cnt = 0;
    end else begin
      if (st_i) m_cnt = m_cnt + 1;
      if (st_i) begin
        m_fp = m_fp | fl_i;
      end else if (fl_i || m_fp) begin
        m_valid = 0; m_rw = 0; m_m2r = 0; m_mr = 0; m_mw = 0; m_fp = 0;
      end else begin
        m_valid = v_i; m_alu = alu_i; m_md = md_i; m_rd = rd_i;
        m_rw = rw_i && (rd_i != 0); m_m2r = m2r_i; m_mr = mr_i; m_mw = mw_i;
      end
    end
  endtask

  task automatic model_check();
    check("valid", {31'd0, v_o}, {31'd0, m_valid});
    check("regwrite", {31'd0, rw_o}, {31'd0, m_valid & m_rw});
    check("memtoreg", {31'd0, m2r_o}, {31'd0, m_valid & m_m2r});
    check("memread", {31'd0, mr_o}, {31'd0, m_valid & m_mr});
    check("memwrite", {31'd0, mw_o}, {31'd0, m_valid & m_mw});
    check("memreq", {31'd0, req_o}, {31'd0, m_valid & (m_mr | m_mw)});
    check("fwden", {31'd0, fwd_o}, {31'd0, m_valid & m_rw & ~m_m2r});
    if (m_valid) begin
      check("aluresult", alu_o, m_alu);
      check("memdata", md_o, m_md);
      check("rdaddr", {27'd0, rd_o}, {27'd0, m_rd});
    end
`ifdef EX_MEM_STALL_CNT_EN
    check("stallcnt", cnt_o, m_cnt);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r, input logic w, input logic m2, input logic rd,
                       input logic wr, input logic s, input logic f);
    v_i = v; alu_i = a; md_i = d; rd_i = r; rw_i = w; m2r_i = m2; mr_i = rd; mw_i = wr;
    st_i = s; fl_i = f;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 1) == 1, $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic v, w, m2, rd, wr, f;
    logic [31:0] a, d;
    logic [4:0] r;
    logic e_v, e_req, e_fwd, e_rw;
    logic [31:0] e_a, e_d;
    logic [4:0] e_r;
  } vec_t;

  vec_t vt[7];
  logic [31:0] h_alu, h_md;
  logic [4:0]  h_rd;
  logic        h_v, h_rw, h_m2r, h_mr, h_mw;

  initial begin
    // table: inputs then expected valid/memreq/fwd/regwrite/alu/mem/rd
    vt[0] = '{1,0,0,0,1,0, 32'h1000, 32'hDEADBEEF, 5'd0, 1,1,0,0, 32'h1000, 32'hDEADBEEF, 5'd0};
    vt[1] = '{1,1,0,0,0,0, 32'h0004, 32'h11111111, 5'd0, 1,0,0,0, 32'h0004, 32'h11111111, 5'd0};
    vt[2] = '{1,1,0,0,0,0, 32'h0008, 32'h22222222, 5'd5, 1,0,1,1, 32'h0008, 32'h22222222, 5'd5};
    vt[3] = '{1,1,1,1,0,0, 32'h3000, 32'h33333333, 5'd5, 1,1,0,1, 32'h3000, 32'h33333333, 5'd5};
    vt[4] = '{0,1,0,0,1,0, 32'h4000, 32'h44444444, 5'd7, 0,0,0,0, 32'h4000, 32'h44444444, 5'd7};
    vt[5] = '{1,1,0,1,0,1, 32'h5000, 32'h55555555, 5'd3, 0,0,0,0, 32'h4000, 32'h44444444, 5'd7};
    vt[6] = '{1,1,0,0,0,0, 32'hFFFFFFFF, 32'h0, 5'd31, 1,0,1,1, 32'hFFFFFFFF, 32'h0, 5'd31};

    // reset with random inputs
    rst = 1'b1;
    drive_random();
    cycle();
    drive_random();
    cycle();
    check("rst_alu", alu_o, 32'd0);
    check("rst_md", md_o, 32'd0);
    check("rst_rd", {27'd0, rd_o}, 32'd0);
    check("rst_valid", {31'd0, v_o}, 32'd0);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].v, vt[i].a, vt[i].d, vt[i].r, vt[i].w, vt[i].m2, vt[i].rd, vt[i].wr, 1'b0, vt[i].f);
      cycle();
      check($sformatf("vec%0d_valid", i), {31'd0, v_o}, {31'd0, vt[i].e_v});
      check($sformatf("vec%0d_memreq", i), {31'd0, req_o}, {31'd0, vt[i].e_req});
      check($sformatf("vec%0d_fwd", i), {31'd0, fwd_o}, {31'd0, vt[i].e_fwd});
      check($sformatf("vec%0d_regwrite", i), {31'd0, rw_o}, {31'd0, vt[i].e_rw});
      if (vt[i].e_v) begin
        check($sformatf("vec%0d_alu", i), alu_o, vt[i].e_a);
        check($sformatf("vec%0d_md", i), md_o, vt[i].e_d);
        check($sformatf("vec%0d_rd", i), {27'd0, rd_o}, {27'd0, vt[i].e_r});
      end
    end

    // stall hold: load a lw, then stall 3 cycles with changing inputs
    rst = 1'b1; drive_random(); cycle(); rst = 1'b0;
    drive(1, 32'h2000, 32'hCAFEF00D, 5'd8, 1, 1, 1, 0, 0, 0);
    cycle();
    h_alu = alu_o; h_md = md_o; h_rd = rd_o; h_v = v_o; h_rw = rw_o;
    h_m2r = m2r_o; h_mr = mr_o; h_mw = mw_o;
    check("lw_memreq", {31'd0, req_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      drive_random();
      st_i = 1'b1;
      cycle();
      check("stall_alu", alu_o, h_alu);
      check("stall_md", md_o, h_md);
      check("stall_bits", {22'd0, rd_o, v_o, rw_o, m2r_o, mr_o, mw_o},
            {22'd0, h_rd, h_v, h_rw, h_m2r, h_mr, h_mw});
      check("stall_memreq", {31'd0, req_o}, 32'd1);
    end
`ifdef EX_MEM_STALL_CNT_EN
    check("stallcnt_3", cnt_o, 32'd3);
`endif

    // flush during stall: held, then bubble, then normal load
    drive(1, 32'h6000, 32'h6, 5'd9, 1, 0, 1, 0, 1, 1);
    cycle();
    check("fds_hold_valid", {31'd0, v_o}, 32'd1);
    drive(1, 32'h7000, 32'h7, 5'd9, 1, 0, 1, 0, 0, 0);
    cycle();
    check("fds_bubble_valid", {31'd0, v_o}, 32'd0);
    check("fds_bubble_req", {31'd0, req_o}, 32'd0);
    cycle();
    check("fds_load_valid", {31'd0, v_o}, 32'd1);
    check("fds_load_alu", alu_o, 32'h7000);

    // reset mid-stall with flush pending: pending flush must be discarded
    drive(1, 32'h8000, 32'h8, 5'd10, 1, 0, 0, 0, 1, 1);
    cycle();
    rst = 1'b1; st_i = 1'b1; fl_i = 1'b0;
    cycle();
    rst = 1'b0;
    drive(1, 32'h9000, 32'h9, 5'd11, 1, 0, 0, 0, 0, 0);
    cycle();
    check("rstpend_valid", {31'd0, v_o}, 32'd1);
    check("rstpend_alu", alu_o, 32'h9000);

    // randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      drive_random();
      st_i = ($urandom_range(0, 3) == 0);
      fl_i = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register of the five-stage core. It captures the EX-stage ALU result, the store data, the destination register and the MEM/WB control bits, and presents them to the L1 data cache and the writeback path. It holds its contents while the data cache stalls and inserts bubbles on flush. It also drives the forwarding taps that the EX-stage operand muxes use.

## Interface
Parameters:
- XLEN, 32, datapath width (ALU result, store data)
- RA_W, 5, register address width

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- Valid_i  in  1  EX stage holds a real instruction
- ALUResult_i  in  XLEN  ALU result (memory address for load/store)
- MemData_i  in  XLEN  forwarded rs2 value (store data)
- RdAddr_i  in  RA_W  destination register
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from ID/EX
- Stall_i  in  1  data cache busy, hold all state
- Flush_i  in  1  squash the instruction entering this cycle
- Valid_o  out  1  register holds a live instruction
- ALUResult_o  out  XLEN  registered result / cache address
- MemData_o  out  XLEN  registered store data
- RdAddr_o  out  RA_W  registered destination
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  registered control, qualified by valid
- MemReq_o  out  1  cache request: Valid_o & (MemRead_o | MemWrite_o)
- FwdEn_o  out  1  forwarding tap valid: Valid_o & RegWrite_o & ~MemtoReg_o
- StallCnt_o  out  32  stall cycle count (only with EX_MEM_STALL_CNT_EN)

## Operation
- Update priority, highest first: reset, then Stall_i (hold), then pending/actual flush (load a bubble), then normal load.
- Reset: Valid_o=0, all data/address outputs 0, all control outputs 0, MemReq_o=0, FwdEn_o=0, flush_pending=0, StallCnt_o=0.
- Normal load, when ~Stall_i and no flush: every field takes its _i value. Valid_o takes Valid_i.
- Write to x0: RegWrite_o is stored as 0 whenever RdAddr_i==0. x0 is therefore never forwarded or written back.
- Bubble: Valid_o=0 and all four control bits 0. Data fields may keep their old values; they are don't-care.
- Flush during stall: Flush_i with Stall_i=1 sets flush_pending and the register holds. On the first cycle with Stall_i=0, a bubble is loaded and flush_pending is cleared.
- Flush_i with Stall_i=0 loads a bubble immediately. Any flush_pending is cleared in the same cycle.
- Stall: all outputs are held bit-exact. MemReq_o stays asserted for the whole stall, so the cache sees a stable request.
- Control outputs are always the stored bits ANDed with Valid_o. An invalid entry never requests memory or writes a register.

## Timing
- Latency: 1 cycle from the _i values to the _o values.
- MemReq_o, FwdEn_o are combinational from the registered state. There is no combinational path from any _i input.
- Stall_i is sampled at the edge. Holding for N cycles delays the next load by N cycles, and no input is lost; the upstream stages stall on the same signal.
- Simultaneous Flush_i and Stall_i: the stall is honoured first and the flush is deferred, as above.
- Reset asserted mid-stall or with a flush pending: the next state is the reset state and the pending flush is discarded.

## Configuration
- EX_MEM_STALL_CNT_EN defined: StallCnt_o exists. It is a 32-bit counter that increments on every cycle with Stall_i=1 and rst_i=0, wraps from 0xFFFFFFFF to 0, and resets to 0.
- Not defined: the StallCnt_o port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - XLEN and RA_W;
  - a packed struct for the MEM/WB control bundle (RegWrite, MemtoReg, MemRead, MemWrite);
  - the bubble constant, which is all zeros.
- One sub-module, stall_counter, instantiated only under EX_MEM_STALL_CNT_EN. Everything else is a single always block plus output assigns.

## Test plan
- Reset: rst_i=1 for 2 cycles with random inputs. Every output must be 0 and StallCnt_o=0.
- Load: ALUResult_i=0x00001000, MemData_i=0xDEADBEEF, RdAddr_i=0, MemWrite_i=1, Valid_i=1. The next cycle must show ALUResult_o=0x1000, MemData_o=0xDEADBEEF, MemReq_o=1, RegWrite_o=0.
- x0 suppression: RdAddr_i=0, RegWrite_i=1. Requires RegWrite_o=0 and FwdEn_o=0. With RdAddr_i=5 instead, requires FwdEn_o=1 and RdAddr_o=5.
- Stall hold: load a lw (MemRead_i=1), then Stall_i=1 for 3 cycles while the inputs change. The outputs must not change, MemReq_o must stay 1, and StallCnt_o must be 3.
- Flush during stall: Flush_i=1 while Stall_i=1, then Stall_i=0. On the first unstalled edge a bubble loads: Valid_o=0, MemReq_o=0. The following edge loads the inputs normally.
- Reset mid-stall with a flush pending: after reset and a normal load, Valid_o=1. This confirms the deferred flush was discarded.
